// File: rtl/matrix_op_defs_pkg.sv
// Shared widths, slot geometry and result codes for the matrix_op_* engines.
// Slot base address helper used by every engine that reads operand slots.
package matrix_op_defs_pkg;

  localparam int MATRIX_DATA_WIDTH     = 32;
  localparam int MATRIX_ADDR_WIDTH     = 10;
  localparam int MATRIX_BLOCK_SIZE     = 64;
  localparam int MATRIX_METADATA_WORDS = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY    = 3'd1,
    SUCCESS = 3'd2,
    ERR_DIM = 3'd3,
    ERR_ID  = 3'd4
  } matrix_op_status_e;

  function automatic logic [MATRIX_ADDR_WIDTH-1:0] slot_base(input logic [2:0] id);
    return MATRIX_ADDR_WIDTH'(id) * MATRIX_ADDR_WIDTH'(MATRIX_BLOCK_SIZE);
  endfunction

endpackage

// File: rtl/matrix_op_mul_mac.sv
// Signed clear/accumulate MAC; result visible the cycle after each accumulate.
// MATRIX_OP_MUL_SATURATE_EN: wide accumulator with clamped result, else modulo-2^DW wrap.
module matrix_op_mul_mac
  import matrix_op_defs_pkg::*;
#(
  parameter int DW = MATRIX_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] result
);

`ifdef MATRIX_OP_MUL_SATURATE_EN
  localparam int ACC_W = 2*DW + 8;

  logic signed [2*DW-1:0]  a_ext, b_ext, prod;
  logic signed [ACC_W-1:0] acc_q;
  logic                    in_range;

  assign a_ext = {{DW{a[DW-1]}}, a};
  assign b_ext = {{DW{b[DW-1]}}, b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= acc_q + {{8{prod[2*DW-1]}}, prod};
  end

  // Representable in DW bits only when every bit above the DW-bit sign agrees with it.
  assign in_range = (acc_q[ACC_W-1:DW-1] == {(ACC_W-DW+1){acc_q[ACC_W-1]}});
  assign result   = in_range      ? acc_q[DW-1:0] :
                    acc_q[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
  logic signed [DW-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= acc_q + a * b;
  end

  assign result = acc_q;
`endif

endmodule

// File: rtl/matrix_op_mul.sv
// C = A x B from shared BRAM slots, streamed into result slot 0 via the writer handshake.
// One element per 3*colsA cycles plus emit; stalls on write_ready/writer_ready. Option: MATRIX_OP_MUL_SATURATE_EN.
module matrix_op_mul
  import matrix_op_defs_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [2:0]                   matrix_a_id,
  input  logic [2:0]                   matrix_b_id,
  output logic                         busy,
  output matrix_op_status_e            status,
  output logic [MATRIX_ADDR_WIDTH-1:0] read_addr,
  input  logic [MATRIX_DATA_WIDTH-1:0] data_out,
  output logic                         write_request,
  input  logic                         write_ready,
  output logic [2:0]                   matrix_id,
  output logic [7:0]                   actual_rows,
  output logic [7:0]                   actual_cols,
  output logic [7:0][7:0]              matrix_name,
  output logic [MATRIX_DATA_WIDTH-1:0] data_in,
  output logic                         data_valid,
  input  logic                         writer_ready,
  input  logic                         write_done
);

  localparam int DW = MATRIX_DATA_WIDTH;
  localparam int AW = MATRIX_ADDR_WIDTH;
  localparam logic [AW-1:0] META_OFS  = AW'(MATRIX_METADATA_WORDS);
  localparam logic [15:0]   MAX_ELEMS = 16'(MATRIX_BLOCK_SIZE - MATRIX_METADATA_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK_ID, S_RD_HDR_A, S_RD_HDR_B, S_CHECK_DIM, S_REQ_WRITE,
    S_RD_A, S_RD_B, S_MAC, S_EMIT, S_WAIT_DONE, S_FINISH
  } state_e;

  state_e               state_q, state_d;
  matrix_op_status_e    status_q, status_d, code_q, code_d;
  logic [2:0]           a_id_q, a_id_d, b_id_q, b_id_d;
  logic [7:0]           rows_a_q, rows_a_d, cols_a_q, cols_a_d, cols_b_q, cols_b_d;
  logic [7:0]           i_q, i_d, j_q, j_d, k_q, k_d;
  logic [AW-1:0]        a_row_q, a_row_d, a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d;
  logic signed [DW-1:0] a_val_q, a_val_d;

  logic                 mac_clr, mac_en;
  logic signed [DW-1:0] mac_result;
  logic [AW-1:0]        base_a, base_b;
  logic [7:0]           hdr_rows, hdr_cols;
  logic [15:0]          c_elems;

  assign base_a   = slot_base(a_id_q);
  assign base_b   = slot_base(b_id_q);
  assign hdr_rows = data_out[DW-1 -: 8];
  assign hdr_cols = data_out[DW-9 -: 8];
  assign c_elems  = 16'(rows_a_q) * 16'(hdr_cols);

  assign busy        = (state_q != S_IDLE);
  assign status      = status_q;
  assign matrix_id   = 3'd0;
  assign actual_rows = rows_a_q;
  assign actual_cols = cols_b_q;
  assign matrix_name = {8'h00, 8'h54, 8'h55, 8'h4F, 8'h5F, 8'h4C, 8'h55, 8'h4D};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      status_q <= IDLE;
      code_q   <= IDLE;
      a_id_q   <= '0;
      b_id_q   <= '0;
      rows_a_q <= '0;
      cols_a_q <= '0;
      cols_b_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_row_q  <= '0;
      a_ptr_q  <= '0;
      b_ptr_q  <= '0;
      a_val_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      code_q   <= code_d;
      a_id_q   <= a_id_d;
      b_id_q   <= b_id_d;
      rows_a_q <= rows_a_d;
      cols_a_q <= cols_a_d;
      cols_b_q <= cols_b_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_row_q  <= a_row_d;
      a_ptr_q  <= a_ptr_d;
      b_ptr_q  <= b_ptr_d;
      a_val_q  <= a_val_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    code_d        = code_q;
    a_id_d        = a_id_q;
    b_id_d        = b_id_q;
    rows_a_d      = rows_a_q;
    cols_a_d      = cols_a_q;
    cols_b_d      = cols_b_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    a_row_d       = a_row_q;
    a_ptr_d       = a_ptr_q;
    b_ptr_d       = b_ptr_q;
    a_val_d       = a_val_q;
    mac_clr       = 1'b0;
    mac_en        = 1'b0;
    read_addr     = '0;
    write_request = 1'b0;
    data_valid    = 1'b0;
    data_in       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_id_d   = matrix_a_id;
          b_id_d   = matrix_b_id;
          status_d = BUSY;
          state_d  = S_CHECK_ID;
        end
      end
      S_CHECK_ID: begin
        if (a_id_q == 3'd0 || b_id_q == 3'd0) begin
          code_d  = ERR_ID;
          state_d = S_FINISH;
        end else begin
          state_d = S_RD_HDR_A;
        end
      end
      S_RD_HDR_A: begin
        read_addr = base_a;
        state_d   = S_RD_HDR_B;
      end
      S_RD_HDR_B: begin
        read_addr = base_b;
        rows_a_d  = hdr_rows;
        cols_a_d  = hdr_cols;
        state_d   = S_CHECK_DIM;
      end
      // Header B is on data_out this cycle; it is judged directly rather than re-registered.
      S_CHECK_DIM: begin
        cols_b_d = hdr_cols;
        if (rows_a_q == 8'd0 || cols_a_q == 8'd0 || hdr_rows == 8'd0 || hdr_cols == 8'd0 ||
            cols_a_q != hdr_rows || c_elems > MAX_ELEMS) begin
          code_d  = ERR_DIM;
          state_d = S_FINISH;
        end else begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          a_row_d = base_a + META_OFS;
          a_ptr_d = base_a + META_OFS;
          b_ptr_d = base_b + META_OFS;
          state_d = S_REQ_WRITE;
        end
      end
      S_REQ_WRITE: begin
        write_request = 1'b1;
        mac_clr       = 1'b1;
        if (write_ready) state_d = S_RD_A;
      end
      S_RD_A: begin
        read_addr = a_ptr_q;
        state_d   = S_RD_B;
      end
      S_RD_B: begin
        read_addr = b_ptr_q;
        a_val_d   = $signed(data_out);
        state_d   = S_MAC;
      end
      S_MAC: begin
        mac_en  = 1'b1;
        k_d     = k_q + 8'd1;
        a_ptr_d = a_ptr_q + AW'(1);
        b_ptr_d = b_ptr_q + AW'(cols_b_q);
        state_d = ((k_q + 8'd1) != cols_a_q) ? S_RD_A : S_EMIT;
      end
      // Pointers walk A along its row and B down its column; a_row_q remembers the row start.
      S_EMIT: begin
        data_valid = 1'b1;
        data_in    = mac_result;
        if (writer_ready) begin
          mac_clr = 1'b1;
          k_d     = '0;
          if ((j_q + 8'd1) != cols_b_q) begin
            j_d     = j_q + 8'd1;
            a_ptr_d = a_row_q;
            b_ptr_d = base_b + META_OFS + AW'(j_q) + AW'(1);
            state_d = S_RD_A;
          end else if ((i_q + 8'd1) != rows_a_q) begin
            i_d     = i_q + 8'd1;
            j_d     = '0;
            a_row_d = a_row_q + AW'(cols_a_q);
            a_ptr_d = a_row_q + AW'(cols_a_q);
            b_ptr_d = base_b + META_OFS;
            state_d = S_RD_A;
          end else begin
            state_d = S_WAIT_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (write_done) begin
          code_d  = SUCCESS;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        status_d = code_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  matrix_op_mul_mac #(.DW(DW)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr),
    .en     (mac_en),
    .a      (a_val_q),
    .b      ($signed(data_out)),
    .result (mac_result)
  );

endmodule

// File: tb/tb_matrix_op_mul.sv
// Directed bench for matrix_op_mul: BRAM and result-slot writer models, hand-computed products.
module tb_matrix_op_mul;
  import matrix_op_defs_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start = 1'b0;
  logic [2:0]                   matrix_a_id = '0;
  logic [2:0]                   matrix_b_id = '0;
  logic                         busy;
  matrix_op_status_e            status;
  logic [MATRIX_ADDR_WIDTH-1:0] read_addr;
  logic [MATRIX_DATA_WIDTH-1:0] data_out = '0;
  logic                         write_request;
  logic                         write_ready;
  logic [2:0]                   matrix_id;
  logic [7:0]                   actual_rows, actual_cols;
  logic [7:0][7:0]              matrix_name;
  logic [MATRIX_DATA_WIDTH-1:0] data_in;
  logic                         data_valid;
  logic                         writer_ready = 1'b1;
  logic                         write_done;

  matrix_op_mul dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix_a_id(matrix_a_id), .matrix_b_id(matrix_b_id),
    .busy(busy), .status(status), .read_addr(read_addr), .data_out(data_out),
    .write_request(write_request), .write_ready(write_ready), .matrix_id(matrix_id),
    .actual_rows(actual_rows), .actual_cols(actual_cols), .matrix_name(matrix_name),
    .data_in(data_in), .data_valid(data_valid), .writer_ready(writer_ready), .write_done(write_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Operand BRAM with one cycle of read latency.
  logic [31:0] bram [0:1023];
  always @(posedge clk) data_out <= bram[read_addr];

  // Result-slot writer model: accepts one request, counts transfers, then pulses write_done.
  logic        wr_busy;
  int          wr_cnt, wr_total;
  int          xfer_cnt = 0;
  int          req_cycles = 0;
  int          rd_cycles = 0;
  logic        stall_en = 1'b0;
  logic [31:0] res_hdr = '0, res_name0 = '0, res_name1 = '0;
  logic [31:0] res_data [0:63];

  assign write_ready = !wr_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_busy    <= 1'b0;
      wr_cnt     <= 0;
      wr_total   <= 0;
      write_done <= 1'b0;
    end else begin
      write_done <= 1'b0;
      if (!wr_busy) begin
        if (write_request) begin
          wr_busy   <= 1'b1;
          wr_cnt    <= 0;
          wr_total  <= int'(actual_rows) * int'(actual_cols);
          res_hdr   <= {actual_rows, actual_cols, 16'h0};
          res_name0 <= {matrix_name[0], matrix_name[1], matrix_name[2], matrix_name[3]};
          res_name1 <= {matrix_name[4], matrix_name[5], matrix_name[6], matrix_name[7]};
        end
      end else if (data_valid && writer_ready) begin
        if (wr_cnt < 64) res_data[wr_cnt] <= data_in;
        wr_cnt   <= wr_cnt + 1;
        xfer_cnt <= xfer_cnt + 1;
      end else if (wr_cnt == wr_total) begin
        write_done <= 1'b1;
        wr_busy    <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (write_request) req_cycles <= req_cycles + 1;
    if (busy && read_addr != '0) rd_cycles <= rd_cycles + 1;
    writer_ready <= stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic load(input int id, input int r, input int c, input int v[12]);
    logic [31:0] rr, cc;
    rr = r;
    cc = c;
    bram[id*64] = {rr[7:0], cc[7:0], 16'h0};
    for (int n = 0; n < r*c && n < 12; n++) bram[id*64 + 3 + n] = v[n];
  endtask

  // Launch one operation and follow it until busy falls; optional ignored start mid-run.
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input int mid_start,
                        output int busy_cyc);
    @(negedge clk);
    matrix_a_id = a;
    matrix_b_id = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1'b1);
    check("status_busy", status, BUSY);
    busy_cyc = 0;
    while (busy && busy_cyc < 5000) begin
      @(negedge clk);
      busy_cyc++;
      if (mid_start != 0 && busy_cyc == mid_start) begin
        matrix_a_id = 3'd3;
        matrix_b_id = 3'd4;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_timeout", busy, 1'b0);
  endtask

  task automatic check_c(input string tag, input int n, input logic [31:0] e[6]);
    for (int q = 0; q < n; q++) check(tag, res_data[q], e[q]);
  endtask

  int cyc, req0, xfer0, rd0;

  initial begin
    load(1, 2, 3, '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0});
    load(2, 3, 2, '{7, 8, 9, 10, 11, 12, 0, 0, 0, 0, 0, 0});
    load(3, 2, 2, '{2, 0, -1, 3, 0, 0, 0, 0, 0, 0, 0, 0});
    load(4, 2, 2, '{4, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0});
    load(5, 3, 4, '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12});
    load(6, 4, 2, '{1, 2, 0, 1, 2, 0, 1, 1, 0, 0, 0, 0});
    load(7, 8, 8, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_status", status, IDLE);
    check("rst_read_addr", read_addr, '0);
    check("rst_write_request", write_request, 1'b0);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_data_in", data_in, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x3 * 3x2
    xfer0 = xfer_cnt;
    run_op(3'd1, 3'd2, 0, cyc);
    check("t1_status", status, SUCCESS);
    check("t1_hdr", res_hdr, {8'd2, 8'd2, 16'h0});
    check("t1_name0", res_name0, 32'h4D554C5F);
    check("t1_name1", res_name1, 32'h4F555400);
    check("t1_xfers", xfer_cnt - xfer0, 4);
    check_c("t1_c", 4, '{32'd58, 32'd64, 32'd139, 32'd154, 0, 0});
    check("t1_matrix_id", matrix_id, 3'd0);

    // signed 2x2 * 2x2
    run_op(3'd3, 3'd4, 0, cyc);
    check("t2_status", status, SUCCESS);
    check_c("t2_c", 4, '{32'd8, 32'd2, 32'd11, 32'd5, 0, 0});

    // 3x4 * 4x2
    run_op(3'd5, 3'd6, 0, cyc);
    check("t3_status", status, SUCCESS);
    check("t3_hdr", res_hdr, {8'd3, 8'd2, 16'h0});
    check_c("t3_c", 6, '{32'd11, 32'd8, 32'd27, 32'd24, 32'd43, 32'd40});

    // inner dimension mismatch
    req0 = req_cycles;
    xfer0 = xfer_cnt;
    run_op(3'd1, 3'd3, 0, cyc);
    check("t4_status", status, ERR_DIM);
    check("t4_busy_pulse", (cyc >= 1), 1'b1);
    check("t4_no_request", req_cycles - req0, 0);
    check("t4_no_xfer", xfer_cnt - xfer0, 0);
    check("t4_slot_hdr", res_hdr, {8'd3, 8'd2, 16'h0});
    check("t4_slot_c0", res_data[0], 32'd11);

    // 8x8 result exceeds slot capacity
    req0 = req_cycles;
    run_op(3'd7, 3'd7, 0, cyc);
    check("t4b_status", status, ERR_DIM);
    check("t4b_no_request", req_cycles - req0, 0);

    // result slot used as operand
    req0 = req_cycles;
    rd0 = rd_cycles;
    run_op(3'd0, 3'd2, 0, cyc);
    check("t5_status", status, ERR_ID);
    check("t5_busy_pulse", (cyc >= 1), 1'b1);
    check("t5_no_request", req_cycles - req0, 0);
    check("t5_no_read", rd_cycles - rd0, 0);

    // writer stalls plus an ignored start mid-run
    stall_en = 1'b1;
    xfer0 = xfer_cnt;
    run_op(3'd1, 3'd2, 5, cyc);
    check("t6_status", status, SUCCESS);
    check("t6_xfers", xfer_cnt - xfer0, 4);
    check("t6_hdr", res_hdr, {8'd2, 8'd2, 16'h0});
    check_c("t6_c", 4, '{32'd58, 32'd64, 32'd139, 32'd154, 0, 0});

    // reset in the middle of an operation
    @(negedge clk);
    matrix_a_id = 3'd1;
    matrix_b_id = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_running", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_status", status, IDLE);
    check("t6_rst_write_request", write_request, 1'b0);
    check("t6_rst_data_valid", data_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd3, 3'd4, 0, cyc);
    check("t6_recover_status", status, SUCCESS);
    check_c("t6_recover_c", 4, '{32'd8, 32'd2, 32'd11, 32'd5, 0, 0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
